iob_split: RTL and testbench



---
 rtl/iob_split_pkg.sv | 32 +++
 rtl/iob_split_dec.sv | 22 ++
 rtl/iob_split.sv | 99 +++++++++
 tb/tb_iob_split.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iob_split_pkg.sv
// rtl/iob_split_pkg.sv - shared state encoding and width helpers for iob_split (IOB_SPLIT_DEC_ERR_EN adds ERR)
package iob_split_pkg;

`ifdef IOB_SPLIT_DEC_ERR_EN
    typedef enum logic [1:0] {
        IOB_SPLIT_IDLE = 2'd0,
        IOB_SPLIT_BUSY = 2'd1,
        IOB_SPLIT_ERR  = 2'd2
    } state_e;
    localparam bit IOB_SPLIT_ERR_EN = 1'b1;
`else
    typedef enum logic [1:0] {
        IOB_SPLIT_IDLE = 2'd0,
        IOB_SPLIT_BUSY = 2'd1
    } state_e;
    localparam bit IOB_SPLIT_ERR_EN = 1'b0;
`endif

    // request = {valid, addr, wdata, wstrb}; response = {rdata, ready}
    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int nb_w(input int n_slaves);
        return $clog2(n_slaves) + (($clog2(n_slaves) == 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/iob_split_dec.sv
// rtl/iob_split_dec.sv - address MSB field to slave index, with clamp and out-of-range flag
module iob_split_dec #(
    parameter int N_SLAVES = 2,
    parameter int NB       = 1
) (
    input  logic [NB-1:0] field_i,
    output logic [NB-1:0] idx_o,
    output logic          oor_o
);

    always_comb begin
        idx_o = field_i;
        oor_o = 1'b0;
        if (N_SLAVES == 1) begin
            idx_o = '0;
        end else if (int'(field_i) >= N_SLAVES) begin
            idx_o = NB'(N_SLAVES - 1);
            oor_o = 1'b1;
        end
    end

endmodule

// File: rtl/iob_split.sv
// rtl/iob_split.sv - 1-to-N iob demux with one tracked outstanding transaction (IOB_SPLIT_DEC_ERR_EN)
module iob_split
    import iob_split_pkg::*;
#(
    parameter int N_SLAVES = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [req_w(ADDR_W, DATA_W)-1:0]           m_req,
    output logic [resp_w(DATA_W)-1:0]                  m_resp,
    output logic [N_SLAVES*req_w(ADDR_W, DATA_W)-1:0]  s_req,
    input  logic [N_SLAVES*resp_w(DATA_W)-1:0]         s_resp
);

    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int RESP_W = resp_w(DATA_W);
    localparam int NB     = nb_w(N_SLAVES);

    state_e          state_q, state_d;
    logic [NB-1:0]   sel_q, sel_d;
    logic [NB-1:0]   dec_idx;
    logic            dec_oor;
    logic [NB-1:0]   cur_sel;
    logic            m_valid;
    logic            route_en;
    logic [RESP_W-1:0] sel_resp;

    iob_split_dec #(
        .N_SLAVES (N_SLAVES),
        .NB       (NB)
    ) u_dec (
        .field_i (m_req[REQ_W-2 -: NB]),
        .idx_o   (dec_idx),
        .oor_o   (dec_oor)
    );

    always_comb begin
        m_valid  = m_req[REQ_W-1];
        state_d  = state_q;
        sel_d    = sel_q;
        route_en = 1'b0;
        m_resp   = '0;
        s_req    = '0;
        sel_resp = '0;
        // once BUSY, the latched index owns routing so a late ready finds its way back
        cur_sel  = (state_q == IOB_SPLIT_IDLE) ? dec_idx : sel_q;

        for (int k = 0; k < N_SLAVES; k++) begin
            if (cur_sel == NB'(k)) sel_resp = s_resp[k*RESP_W +: RESP_W];
        end

        case (state_q)
            IOB_SPLIT_IDLE: begin
                route_en = m_valid & ~(IOB_SPLIT_ERR_EN & dec_oor);
                if (route_en) begin
                    m_resp = sel_resp;
                    if (!sel_resp[0]) begin
                        state_d = IOB_SPLIT_BUSY;
                        sel_d   = dec_idx;
                    end
                end
`ifdef IOB_SPLIT_DEC_ERR_EN
                else if (m_valid && dec_oor) begin
                    state_d = IOB_SPLIT_ERR;
                end
`endif
            end
            IOB_SPLIT_BUSY: begin
                route_en = 1'b1;
                m_resp   = sel_resp;
                if (sel_resp[0]) state_d = IOB_SPLIT_IDLE;
            end
`ifdef IOB_SPLIT_DEC_ERR_EN
            IOB_SPLIT_ERR: begin
                m_resp  = {{DATA_W{1'b1}}, 1'b1};
                state_d = IOB_SPLIT_IDLE;
            end
`endif
            default: state_d = IOB_SPLIT_IDLE;
        endcase

        for (int k = 0; k < N_SLAVES; k++) begin
            if (route_en && (cur_sel == NB'(k))) s_req[k*REQ_W +: REQ_W] = m_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IOB_SPLIT_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_iob_split.sv
// tb/tb_iob_split.sv - directed self-checking bench for iob_split, N_SLAVES=3
module tb_iob_split;

    localparam int N      = 3;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [REQ_W-1:0]    m_req;
    logic [RESP_W-1:0]   m_resp;
    logic [N*REQ_W-1:0]  s_req;
    logic [N*RESP_W-1:0] s_resp;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_split #(
        .N_SLAVES (N),
        .DATA_W   (DW),
        .ADDR_W   (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk(input logic v, input logic [31:0] a,
                                           input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    function automatic logic [N-1:0] valids(input logic [N*REQ_W-1:0] s);
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = s[k*REQ_W + REQ_W - 1];
        return v;
    endfunction

    task automatic set_resp(input int k, input logic [31:0] d, input logic r);
        s_resp[k*RESP_W +: RESP_W] = {d, r};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        m_req  = '0;
        s_resp = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", dut.state_q, 0);
        check("reset_sreq", s_req, 0);
        check("reset_mresp", m_resp, 0);

        // a ready slave must not leak to the master while valid is low
        set_resp(0, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("idle_gate", m_resp, 0);
        s_resp = '0;

        // zero-wait write to slave 1
        step();
        m_req = mk(1'b1, 32'h4000_0010, 32'hA5A5_A5A5, 4'hF);
        set_resp(1, 32'h0, 1'b1);
        @(negedge clk);
        check("zw_valids", valids(s_req), 3'b010);
        check("zw_slot1", s_req[1*REQ_W +: REQ_W], mk(1'b1, 32'h4000_0010, 32'hA5A5_A5A5, 4'hF));
        check("zw_resp", m_resp, {32'h0, 1'b1});
        step();
        m_req = '0;
        s_resp = '0;
        check("zw_state", dut.state_q, 0);

        // waited read from slave 2, ready after three BUSY cycles
        m_req = mk(1'b1, 32'h8000_0004, 32'h0, 4'h0);
        @(negedge clk);
        check("wr_valids", valids(s_req), 3'b100);
        check("wr_resp0", m_resp, 0);
        step();
        check("wr_busy1", dut.state_q, 1);
        m_req = mk(1'b1, 32'h0000_0004, 32'h0, 4'h0);
        @(negedge clk);
        check("wr_hold", valids(s_req), 3'b100);
        step();
        check("wr_busy2", dut.state_q, 1);
        step();
        check("wr_busy3", dut.state_q, 1);
        set_resp(2, 32'h1234_5678, 1'b1);
        @(negedge clk);
        check("wr_data", m_resp, {32'h1234_5678, 1'b1});
        step();
        m_req = '0;
        s_resp = '0;
        check("wr_idle", dut.state_q, 0);

        // spurious ready from slave 1 while waiting on slave 0
        m_req = mk(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        @(negedge clk);
        check("sp_valids", valids(s_req), 3'b001);
        step();
        set_resp(1, 32'hFFFF_0000, 1'b1);
        @(negedge clk);
        check("sp_gate", m_resp, 0);
        step();
        s_resp = '0;
        set_resp(0, 32'hCAFE_BABE, 1'b1);
        @(negedge clk);
        check("sp_done", m_resp, {32'hCAFE_BABE, 1'b1});
        step();
        m_req = '0;
        s_resp = '0;

        // back-to-back slave 0 then slave 2
        m_req = mk(1'b1, 32'h0000_0008, 32'h1111_1111, 4'hF);
        set_resp(0, 32'h0, 1'b1);
        @(negedge clk);
        check("bb0_valids", valids(s_req), 3'b001);
        check("bb0_ready", m_resp, {32'h0, 1'b1});
        step();
        m_req = mk(1'b1, 32'h8000_0008, 32'h2222_2222, 4'hF);
        s_resp = '0;
        set_resp(0, 32'h0BAD_0BAD, 1'b1);
        set_resp(2, 32'h0000_2222, 1'b1);
        @(negedge clk);
        check("bb2_valids", valids(s_req), 3'b100);
        check("bb2_resp", m_resp, {32'h0000_2222, 1'b1});
        step();
        m_req = '0;
        s_resp = '0;
        check("bb_state", dut.state_q, 0);

        // reset while BUSY on slave 1
        m_req = mk(1'b1, 32'h4000_0000, 32'h0, 4'h0);
        step();
        check("rm_busy", dut.state_q, 1);
        check("rm_sel_busy", dut.sel_q, 1);
        rst   = 1'b1;
        m_req = '0;
        step();
        rst = 1'b0;
        check("rm_state", dut.state_q, 0);
        check("rm_sel", dut.sel_q, 0);
        @(negedge clk);
        check("rm_sreq", s_req, 0);
        check("rm_mresp", m_resp, 0);

        // out-of-range index 3
        step();
        m_req = mk(1'b1, 32'hC000_0000, 32'h0, 4'h0);
        set_resp(2, 32'h0000_55AA, 1'b1);
`ifdef IOB_SPLIT_DEC_ERR_EN
        @(negedge clk);
        check("oor_valids", valids(s_req), 3'b000);
        check("oor_resp0", m_resp, 0);
        step();
        check("oor_state", dut.state_q, 2);
        @(negedge clk);
        check("oor_err", m_resp, {32'hFFFF_FFFF, 1'b1});
        check("oor_err_valids", valids(s_req), 3'b000);
        step();
`else
        @(negedge clk);
        check("oor_valids", valids(s_req), 3'b100);
        check("oor_resp", m_resp, {32'h0000_55AA, 1'b1});
        step();
`endif
        m_req = '0;
        s_resp = '0;
        check("oor_idle", dut.state_q, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
